// File: rtl/dmem_pkg.sv
// Shared types for the backing data memory: FSM state encoding and the
// request record carried through the request queue.
package dmem_pkg;

  localparam int DMEM_ADDR_SIZE = 10;
  localparam int DMEM_DATA_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic                      we;
    logic [DMEM_ADDR_SIZE-1:0] addr;
    logic [DMEM_DATA_SIZE-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_backing_if.sv
// Cache-to-backing-memory port: request channel and response channel,
// each with its own valid/ready handshake.
interface dmem_backing_if #(
  parameter int ADDR_SIZE = 10,
  parameter int DATA_SIZE = 32
);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [DATA_SIZE-1:0] req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 resp_we;
  logic [DATA_SIZE-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_we, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_we, resp_rdata
  );

endinterface

// File: rtl/dmem_req_fifo.sv
// In-order circular request queue; head entry is presented combinationally
// so the FSM can pop it straight into its active registers.
module dmem_req_fifo #(
  parameter int  QDEPTH = 2,
  parameter type T      = dmem_pkg::dmem_req_t,
  localparam int CW     = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  T              slots [QDEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (push && wr_ptr_reg == PW'(gi)) begin
        slots[gi] <= din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = slots[rd_ptr_reg];
  assign full  = (count_reg == CW'(QDEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/dmem_backing.sv
// Backing data memory behind the data cache: queued requests are executed
// against a word array after a fixed latency and answered strictly in order.
module dmem_backing
  import dmem_pkg::*;
#(
  parameter int ADDR_SIZE = 10,
  parameter int DATA_SIZE = 32,
  parameter int LATENCY   = 5,
  parameter int QDEPTH    = 2
) (
  input  logic           clk,
  input  logic           rst,
  dmem_backing_if.slave  bus,
  output logic           busy
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_RESP   = RESP;
  localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int CW   = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic                 we;
    logic [ADDR_SIZE-1:0] addr;
    logic [DATA_SIZE-1:0] wdata;
  } req_t;

  logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];

  logic [1:0]           state_reg;
  logic [CNTW-1:0]      cnt_reg;
  req_t                 act_reg;
  logic                 resp_we_reg;
  logic [DATA_SIZE-1:0] resp_rdata_reg;

  req_t                 fifo_din;
  req_t                 fifo_dout;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic                 commit;

  assign fifo_din  = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
  assign fifo_push = bus.req_valid && !fifo_full;
  // Pop from IDLE, or straight out of RESP on the handshake so there is no idle bubble.
  assign fifo_pop  = !fifo_empty &&
                     ((state_reg == ST_IDLE) || (state_reg == ST_RESP && bus.resp_ready));
  assign commit    = (state_reg == ST_ACCESS) && (cnt_reg == '0);

  dmem_req_fifo #(
    .QDEPTH (QDEPTH),
    .T      (req_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A write whose commit edge coincides with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && commit && act_reg.we) begin
      mem[act_reg.addr] <= act_reg.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      act_reg        <= '0;
      resp_we_reg    <= 1'b0;
      resp_rdata_reg <= '0;
    end else begin
      if (fifo_pop) begin
        act_reg   <= fifo_dout;
        cnt_reg   <= CNTW'(LATENCY - 1);
        state_reg <= ST_ACCESS;
      end else begin
        case (state_reg)
          ST_IDLE: state_reg <= ST_IDLE;
          ST_ACCESS: begin
            if (cnt_reg != '0) begin
              cnt_reg <= cnt_reg - 1'b1;
            end else begin
              resp_we_reg    <= act_reg.we;
              resp_rdata_reg <= act_reg.we ? '0 : mem[act_reg.addr];
              state_reg      <= ST_RESP;
            end
          end
          ST_RESP: begin
            if (bus.resp_ready) state_reg <= ST_IDLE;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.req_ready  = !fifo_full;
  assign bus.resp_valid = (state_reg == ST_RESP);
  assign bus.resp_we    = resp_we_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign busy           = (fifo_count != '0) || (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dmem_backing.sv
// Directed bench for dmem_backing (LATENCY=5, QDEPTH=2): latency, ordering,
// backpressure, queue-full hold-off and mid-operation reset.
module tb_dmem_backing;

  logic clk;
  logic rst;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  dmem_backing_if #(.ADDR_SIZE(10), .DATA_SIZE(32)) bus ();

  dmem_backing #(
    .ADDR_SIZE (10),
    .DATA_SIZE (32),
    .LATENCY   (5),
    .QDEPTH    (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer one request at a negedge; returns at the negedge after it is accepted.
  task automatic push(input logic we, input logic [9:0] a, input logic [31:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("push_ready", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    $display("push we=%0d addr=%03h data=%08h", we, a, d);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.resp_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, bus.resp_valid, 1);
  endtask

  // Waits for a response, checks it, then lets the handshake edge pass (resp_ready=1).
  task automatic wait_resp(input string tag, input logic we_exp, input logic [31:0] d_exp);
    wait_valid(tag);
    chk({tag, "_we"}, bus.resp_we, we_exp);
    chk({tag, "_rdata"}, bus.resp_rdata, d_exp);
    $display("resp %s we=%0d rdata=%08h", tag, bus.resp_we, bus.resp_rdata);
    step();
  endtask

  initial begin
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    step();
    step();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_we", bus.resp_we, 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    rst = 1'b1;
    step();
    chk("idle_req_ready", bus.req_ready, 1);
    chk("idle_resp_valid", bus.resp_valid, 0);
    chk("idle_busy", busy, 0);

    // Latency: accept at T, response valid only after edge T+6.
    push(1'b1, 10'h3A1, 32'hDEADBEEF);
    chk("lat_busy", busy, 1);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("lat_valid_T%0d", k), bus.resp_valid, (k == 6) ? 1 : 0);
      if (k == 6) begin
        chk("lat_we", bus.resp_we, 1);
        chk("lat_rdata", bus.resp_rdata, 0);
      end
    end
    push(1'b0, 10'h3A1, 32'h0);
    wait_resp("rd_3a1", 1'b0, 32'hDEADBEEF);

    // Read immediately after write to the same address.
    push(1'b1, 10'h055, 32'h1);
    push(1'b0, 10'h055, 32'h0);
    wait_resp("wr_055", 1'b1, 32'h0);
    wait_resp("rd_055", 1'b0, 32'h1);

    // Queue fill with the FSM busy and the consumer stalled.
    bus.resp_ready = 1'b0;
    push(1'b1, 10'h100, 32'hA);
    push(1'b1, 10'h101, 32'hB);
    push(1'b0, 10'h100, 32'h0);
    chk("full_req_ready", bus.req_ready, 0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 10'h101;
    bus.req_wdata = 32'h0;
    wait_valid("hold_a");
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_valid", bus.resp_valid, 1);
      chk("hold_we", bus.resp_we, 1);
      chk("hold_rdata", bus.resp_rdata, 0);
      chk("hold_req_ready", bus.req_ready, 0);
    end
    $display("resp hold_a we=%0d rdata=%08h", bus.resp_we, bus.resp_rdata);
    bus.resp_ready = 1'b1;
    step();
    chk("rel_valid", bus.resp_valid, 0);
    chk("rel_req_ready", bus.req_ready, 1);
    // The next request popped on the release edge answers 5 edges later.
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) bus.req_valid = 1'b0;
      chk($sformatf("b2b_valid_E%0d", k), bus.resp_valid, (k == 5) ? 1 : 0);
    end
    chk("b_we", bus.resp_we, 1);
    chk("b_rdata", bus.resp_rdata, 0);
    $display("resp b we=%0d rdata=%08h", bus.resp_we, bus.resp_rdata);
    step();
    wait_resp("c_rd_100", 1'b0, 32'hA);
    wait_resp("d_rd_101", 1'b0, 32'hB);

    // Reset in the middle of a write's ACCESS phase.
    push(1'b1, 10'h010, 32'h7);
    wait_resp("wr_010", 1'b1, 32'h0);
    push(1'b0, 10'h3A1, 32'h0);
    wait_resp("rd_3a1_again", 1'b0, 32'hDEADBEEF);
    push(1'b1, 10'h010, 32'h99);
    step();
    step();
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    step();
    chk("mid_rst_req_ready", bus.req_ready, 1);
    chk("mid_rst_resp_valid", bus.resp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_resp_we", bus.resp_we, 0);
    chk("mid_rst_rdata", bus.resp_rdata, 0);
    step();
    rst = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      step();
    end
    chk("post_rst_valid", bus.resp_valid, 0);
    push(1'b0, 10'h010, 32'h0);
    wait_resp("rd_010_after_rst", 1'b0, 32'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_backing.md
# dmem_backing

Backing data memory that sits directly downstream of the data cache and services its miss fills and dirty-line writebacks. Requests enter through a valid/ready port into a small in-order queue. Each request is executed against a word-addressed array after a fixed, parameterised latency. Results return on a valid/ready response port, one response per request, in request order.

## Interface
- `ADDR_SIZE`, default 10: word address width; must equal the cache's full block-address width. The array holds 2**ADDR_SIZE words.
- `DATA_SIZE`, default 32: word width.
- `LATENCY`, default 5: access cycles per request, counted from pop; must be ≥1.
- `QDEPTH`, default 2: request queue depth; must be ≥1.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: queue can accept a request.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input ADDR_SIZE: word address.
- `req_wdata` input DATA_SIZE: write data; ignored for reads.
- `resp_valid` output 1: response present.
- `resp_ready` input 1: consumer accepts the response.
- `resp_we` output 1: echoes `req_we` of the request being answered.
- `resp_rdata` output DATA_SIZE: read data; 0 for write acknowledgements.
- `busy` output 1: queue non-empty or FSM not in IDLE.

## Operation
- Push: on an edge with `req_valid && req_ready`, {we, addr, wdata} is appended to the queue.
- `req_ready` = (count < QDEPTH).
  - It depends on count only, so no push occurs while full, even in a cycle where a pop also happens.
- FSM states IDLE, ACCESS, RESP.
- IDLE:
  - Queue empty: stay in IDLE.
  - Queue non-empty: pop the head into the active registers, load `cnt` = LATENCY-1, go to ACCESS.
- ACCESS:
  - `cnt` != 0: decrement `cnt`.
  - `cnt` == 0, write: on this edge, write `array[addr]` = `wdata` and set `resp_rdata` = 0.
  - `cnt` == 0, read: on this edge, set `resp_rdata` = `array[addr]`.
  - In both cases, set `resp_we` = `we` and go to RESP.
- RESP:
  - `resp_valid` = 1; `resp_rdata` and `resp_we` are held stable until the response is accepted.
  - `resp_ready` = 1 and queue non-empty: pop the head directly into ACCESS. There is no idle bubble.
  - `resp_ready` = 1 and queue empty: go to IDLE.
  - `resp_ready` = 0: stay in RESP.
- Ordering is strict FIFO: a read issued after a write to the same address returns the written data.
- Simultaneous push and pop: both take effect on the same edge and count is unchanged; allowed whenever count < QDEPTH.
- Queue pointers wrap modulo QDEPTH. Count width is $clog2(QDEPTH+1).
- Array contents are not cleared by reset. Reads of never-written addresses return X; the bench writes before it reads.

## Timing
- Reset values:
  - `req_ready` = 1, `resp_valid` = 0, `resp_we` = 0, `resp_rdata` = 0, `busy` = 0.
  - Queue count 0, state IDLE, `cnt` 0.
- Latency, for a request accepted at edge T with the FSM idle and the queue empty:
  - Pop occurs at edge T+1.
  - Array commit occurs at edge T+LATENCY+1.
  - `resp_valid` is high from edge T+LATENCY+1.
  - With `resp_ready` held at 1, `resp_valid` is high for exactly one cycle.
- Back-to-back throughput with `resp_ready` held at 1: one response every LATENCY+1 cycles.
- Reset asserted mid-operation:
  - The queue and the in-flight request are discarded.
  - The array write is not performed unless its commit edge preceded the reset edge.
  - Outputs return to their reset values on the reset edge.
- `resp_valid` never deasserts without a handshake. `req_ready` may drop in the cycle after a push that fills the queue.

## Structure
- Package `dmem_pkg`:
  - `dmem_state_t` enum {IDLE, ACCESS, RESP}.
  - `dmem_req_t` packed struct {we, addr, wdata}, sized from package localparams matching the defaults.
- Sub-module `dmem_req_fifo`: parameterised QDEPTH circular queue of `dmem_req_t`, with push/pop, full/empty, and count outputs.
- Top level holds the FSM, latency counter, array, and response registers.

## Test plan
- Reset, then idle → `req_ready`=1, `resp_valid`=0, `busy`=0.
- Write addr 0x3A1 data 0xDEADBEEF at edge T, `resp_ready`=1 → `resp_valid`=1 with `resp_we`=1 and `rdata`=0 only in the cycle after edge T+6. Then read 0x3A1 → `rdata`=0xDEADBEEF, `resp_we`=0.
- Push 3 requests back-to-back with QDEPTH=2 and the FSM busy → third is held off by `req_ready`=0 until a pop. All 3 responses return in order.
- Hold `resp_ready`=0 for 10 cycles during RESP → `resp_valid`, `rdata`, and `resp_we` are stable throughout. On release, the next queued request enters ACCESS on the same edge.
- Write 0x055 := 0x1, then immediately read 0x055 → read returns 0x1.
- Assert `rst` during ACCESS of a write to 0x010 (old value 0x7) → reset values on the outputs; a later read of 0x010 returns 0x7.
